// File: rtl/tap_pkg.sv
// Shared definitions for the JTAG TAP controller: state width, the 1149.1 state
// encoding and the TMS-run saturation limit.
package tap_pkg;

    localparam int unsigned STATE_W = 4;

    // 1149.1 state encoding; bit 3 marks the IR column (plus TLR/RTI).
    typedef enum logic [STATE_W-1:0] {
        StEx2Dr  = 4'h0,
        StEx1Dr  = 4'h1,
        StShDr   = 4'h2,
        StPaDr   = 4'h3,
        StSelIr  = 4'h4,
        StUpDr   = 4'h5,
        StCapDr  = 4'h6,
        StSelDr  = 4'h7,
        StEx2Ir  = 4'h8,
        StEx1Ir  = 4'h9,
        StShIr   = 4'hA,
        StPaIr   = 4'hB,
        StRti    = 4'hC,
        StUpIr   = 4'hD,
        StCapIr  = 4'hE,
        StTlr    = 4'hF
    } tap_state_e;

    // Five TMS=1 edges reach Test-Logic-Reset from anywhere.
    localparam logic [2:0] TLR_SAT = 3'd5;

endpackage

// File: rtl/tap_decode.sv
// Combinational state-to-strobe decoder for the TAP controller.
// Kept separate so the strobe table can be reviewed on its own.
module tap_decode
    import tap_pkg::*;
(
    input  tap_state_e state,
    output logic       ShiftIR,
    output logic       ClockIR,
    output logic       UpdateIR,
    output logic       ShiftDR,
    output logic       ClockDR,
    output logic       UpdateDR,
    output logic       ResetIR,
    output logic       Select,
    output logic       Enable
);

    // Moore decode: every strobe depends on the state flops only.
    always_comb begin
        ShiftIR  = (state == StShIr);
        ClockIR  = (state == StCapIr) || (state == StShIr);
        UpdateIR = (state == StUpIr);
        ShiftDR  = (state == StShDr);
        ClockDR  = (state == StCapDr) || (state == StShDr);
        UpdateDR = (state == StUpDr);
        ResetIR  = (state == StTlr);
        Select   = state[3];
        Enable   = (state == StShIr) || (state == StShDr);
    end

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: TMS-driven state machine on TCK plus strobe decode.
// Optional macro TAP_STATE_OUT_EN exposes the state register (State) and a
// saturating count of consecutive TMS=1 edges (TlrCount) for debug.
module tap_controller
    import tap_pkg::*;
#(
    parameter int unsigned STATE_W      = 4,
    parameter bit          TLR_ON_RESET = 1'b1
) (
    input  logic TCK,
    input  logic Reset,
    input  logic TMS,
    output logic ShiftIR,
    output logic ClockIR,
    output logic UpdateIR,
    output logic ShiftDR,
    output logic ClockDR,
    output logic UpdateDR,
    output logic ResetIR,
    output logic Select,
    output logic Enable
`ifdef TAP_STATE_OUT_EN
    ,
    output logic [STATE_W-1:0] State,
    output logic [2:0]         TlrCount
`endif
);

    // The encoding is fixed by the standard; any other width is a build error.
    if (STATE_W != tap_pkg::STATE_W) begin : gen_bad_state_w
        $error("tap_controller: STATE_W must be 4");
    end

    localparam tap_state_e ResetState = TLR_ON_RESET ? StTlr : StRti;

    tap_state_e state_q, state_d;

    // State register; synchronous reset overrides TMS.
    always_ff @(posedge TCK) begin
        if (Reset) begin
            state_q <= ResetState;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic following the 1149.1 transition diagram.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTlr:   state_d = TMS ? StTlr   : StRti;
            StRti:   state_d = TMS ? StSelDr : StRti;
            StSelDr: state_d = TMS ? StSelIr : StCapDr;
            StCapDr: state_d = TMS ? StEx1Dr : StShDr;
            StShDr:  state_d = TMS ? StEx1Dr : StShDr;
            StEx1Dr: state_d = TMS ? StUpDr  : StPaDr;
            StPaDr:  state_d = TMS ? StEx2Dr : StPaDr;
            StEx2Dr: state_d = TMS ? StUpDr  : StShDr;
            StUpDr:  state_d = TMS ? StSelDr : StRti;
            StSelIr: state_d = TMS ? StTlr   : StCapIr;
            StCapIr: state_d = TMS ? StEx1Ir : StShIr;
            StShIr:  state_d = TMS ? StEx1Ir : StShIr;
            StEx1Ir: state_d = TMS ? StUpIr  : StPaIr;
            StPaIr:  state_d = TMS ? StEx2Ir : StPaIr;
            StEx2Ir: state_d = TMS ? StUpIr  : StShIr;
            StUpIr:  state_d = TMS ? StSelDr : StRti;
        endcase
    end

    tap_decode u_decode (
        .state    (state_q),
        .ShiftIR  (ShiftIR),
        .ClockIR  (ClockIR),
        .UpdateIR (UpdateIR),
        .ShiftDR  (ShiftDR),
        .ClockDR  (ClockDR),
        .UpdateDR (UpdateDR),
        .ResetIR  (ResetIR),
        .Select   (Select),
        .Enable   (Enable)
    );

`ifdef TAP_STATE_OUT_EN
    logic [2:0] tlr_count_q;

    // Count consecutive TMS=1 edges, saturating at the TLR-reach limit.
    always_ff @(posedge TCK) begin
        if (Reset || !TMS) begin
            tlr_count_q <= 3'd0;
        end else if (tlr_count_q != TLR_SAT) begin
            tlr_count_q <= tlr_count_q + 3'd1;
        end
    end

    assign State    = state_q;
    assign TlrCount = tlr_count_q;
`endif

endmodule
